// File: rtl/fft_mag_scaler.sv
// fft_mag_scaler: complex FFT bin stream -> saturated display heights, with frame checking.
// Define FFT_PEAK_HOLD_EN to add per-bin peak hold with linear decay.
module fft_mag_scaler #(
  parameter int DATA_W    = 16,
  parameter int FFT_POINT = 256,
  parameter int BIN_W     = 8,
  parameter int SHIFT     = 6,
  parameter int OUT_MAX   = 480
`ifdef FFT_PEAK_HOLD_EN
  ,
  parameter int DECAY     = 2
`endif
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_valid,
  output logic [31:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_valid,
  output logic [BIN_W-1:0] out_bin,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int MAG_W = 18;
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(FFT_POINT - 1);
  localparam logic [15:0]       H_MAX    = 16'(OUT_MAX - 1);
  localparam logic [DATA_W-1:0] ABS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, FRAME} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] cur_bin, bin_nxt;

  logic             beat_acc;
  logic             beat_sop;
  logic             beat_eop;
  logic             beat_err;
  logic [BIN_W-1:0] beat_bin;

  logic signed [DATA_W-1:0] re_in, im_in;

  logic              s1_valid, s1_sop, s1_eop, s1_err;
  logic [BIN_W-1:0]  s1_bin;
  logic [DATA_W-1:0] s1_re_abs, s1_im_abs;

  logic              s2_valid, s2_sop, s2_eop, s2_err;
  logic [BIN_W-1:0]  s2_bin;
  logic [DATA_W-1:0] s2_mx, s2_mn;

  logic [MAG_W-1:0]  mag, h_raw;
  logic [15:0]       h_sat, height;

  assign re_in = in_data[31:16];
  assign im_in = in_data[15:0];

  // The most negative input has no positive twin; clamp it instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] v);
    if (v == MOST_NEG)
      return ABS_MAX;
    else if (v[DATA_W-1])
      return -v;
    else
      return v;
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_bin <= '0;
    end else begin
      state   <= state_nxt;
      cur_bin <= bin_nxt;
    end
  end

  // A frame always closes at the last bin, whether or not eop arrived there.
  always_comb begin
    state_nxt = state;
    bin_nxt   = cur_bin;
    beat_acc  = 1'b0;
    beat_sop  = 1'b0;
    beat_eop  = 1'b0;
    beat_err  = 1'b0;
    beat_bin  = cur_bin;
    if (in_valid) begin
      if (in_sop) begin
        beat_acc = 1'b1;
        beat_sop = 1'b1;
        beat_bin = '0;
        beat_err = (state == FRAME);
      end else if (state == FRAME) begin
        beat_acc = 1'b1;
        beat_bin = cur_bin + BIN_W'(1);
      end
      if (beat_acc) begin
        bin_nxt   = beat_bin;
        state_nxt = FRAME;
        if (in_eop || beat_bin == LAST_BIN) begin
          beat_eop  = 1'b1;
          state_nxt = IDLE;
          if (!(in_eop && beat_bin == LAST_BIN))
            beat_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_err    <= 1'b0;
      s1_bin    <= '0;
      s1_re_abs <= '0;
      s1_im_abs <= '0;
      s2_valid  <= 1'b0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
      s2_err    <= 1'b0;
      s2_bin    <= '0;
      s2_mx     <= '0;
      s2_mn     <= '0;
    end else begin
      s1_valid  <= beat_acc;
      s1_sop    <= beat_sop;
      s1_eop    <= beat_eop;
      s1_err    <= beat_err;
      s1_bin    <= beat_bin;
      s1_re_abs <= sat_abs(re_in);
      s1_im_abs <= sat_abs(im_in);
      s2_valid  <= s1_valid;
      s2_sop    <= s1_sop;
      s2_eop    <= s1_eop;
      s2_err    <= s1_err;
      s2_bin    <= s1_bin;
      s2_mx     <= (s1_re_abs > s1_im_abs) ? s1_re_abs : s1_im_abs;
      s2_mn     <= (s1_re_abs > s1_im_abs) ? s1_im_abs : s1_re_abs;
    end
  end

  // max + 3/8 min approximates sqrt(re^2 + im^2) within a few percent.
  assign mag   = MAG_W'(s2_mx) + MAG_W'(s2_mn >> 2) + MAG_W'(s2_mn >> 3);
  assign h_raw = mag >> SHIFT;
  assign h_sat = (h_raw > MAG_W'(OUT_MAX - 1)) ? H_MAX : h_raw[15:0];

`ifdef FFT_PEAK_HOLD_EN
  logic [15:0] hold [FFT_POINT];
  logic [15:0] hold_cur, hold_dec;

  assign hold_cur = hold[s2_bin];
  assign hold_dec = (hold_cur > 16'(DECAY)) ? hold_cur - 16'(DECAY) : '0;
  assign height   = (h_sat > hold_dec) ? h_sat : hold_dec;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_POINT; i++)
        hold[i] <= '0;
    end else if (s2_valid) begin
      hold[s2_bin] <= height;
    end
  end
`else
  assign height = h_sat;
`endif

  // Data-bearing outputs hold through bubbles; frame_cnt lags the good eop by one cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_bin   <= '0;
      frame_cnt <= '0;
    end else begin
      out_valid <= s2_valid;
      frame_err <= s2_valid & s2_err;
      if (s2_valid) begin
        out_data <= {16'd0, height};
        out_sop  <= s2_sop;
        out_eop  <= s2_eop;
        out_bin  <= s2_bin;
      end
      if (out_valid && out_eop && !frame_err)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
